// File: rtl/note_judge_ctrl.sv
// ---------------------------------------------------------------------------
// note_judge_ctrl
//
// Sequencer and scorer for the rhythm-game note-judging datapath.
// Walks the row index through the note array (one row every ROW_FRAMES
// video frames), detects fresh J/K/L key presses from the USB keycode,
// judges every non-rest row exactly once as a hit or a miss inside the
// timing window at the tail of the row, and keeps score and streak.
//
// Ports
//   Clk          in   system clock
//   Reset_n      in   asynchronous active-low reset
//   frame_tick   in   one-cycle pulse per video frame
//   start        in   level; starts/restarts a song from IDLE or DONE
//   keycode      in   two USB scancodes, [15:8] and [7:0]
//   lane_req     in   note pattern of the current row (100/010/001/000)
//   row_counter  out  current row index
//   score        out  accumulated score, saturating at 0xFFFF
//   streak       out  consecutive hits, saturating at 255
//   hit          out  one-cycle pulse on a hit
//   miss         out  one-cycle pulse on a miss
//   playing      out  high while a song is running
//   done         out  high once the last row has finished
// ---------------------------------------------------------------------------
module note_judge_ctrl #(
    parameter int NUM_ROWS   = 100,
    parameter int ROW_FRAMES = 30,
    parameter int WINDOW     = 8,
    parameter int POINTS     = 10,
    parameter int ROW_W      = 7
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             frame_tick,
    input  logic             start,
    input  logic [15:0]      keycode,
    input  logic [2:0]       lane_req,
    output logic [ROW_W-1:0] row_counter,
    output logic [15:0]      score,
    output logic [7:0]       streak,
    output logic             hit,
    output logic             miss,
    output logic             playing,
    output logic             done
);

    localparam int FC_W = (ROW_FRAMES > 1) ? $clog2(ROW_FRAMES) : 1;
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(ROW_FRAMES - 1);
    localparam logic [FC_W-1:0]  WIN_OPEN = FC_W'(ROW_FRAMES - WINDOW);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
    localparam logic [16:0]      POINTS_X = 17'(POINTS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [FC_W-1:0]  fc_q, fc_d;
    logic [15:0]      score_q, score_d;
    logic [7:0]       streak_q, streak_d;
    logic             judged_q, judged_d;
    logic [2:0]       keys_prev_q, keys_prev_d;
    logic             hit_q, hit_d;
    logic             miss_q, miss_d;
    logic             playing_q, playing_d;
    logic             done_q, done_d;

    logic [2:0]       keys_now;
    logic [2:0]       press;
    logic             window_open;
    logic             judge_now;
    logic             row_end;
    logic [16:0]      score_sum;

    // Map one scancode byte to its lane bit; anything else is ignored.
    function automatic logic [2:0] decode_key(input logic [7:0] code);
        logic [2:0] lane;
        case (code)
            8'h0D:   lane = 3'b100;
            8'h0E:   lane = 3'b010;
            8'h0F:   lane = 3'b001;
            default: lane = 3'b000;
        endcase
        return lane;
    endfunction

    // A press is a lane that is down now but was not down last cycle, so a
    // key held across rows never re-triggers.
    assign keys_now    = decode_key(keycode[15:8]) | decode_key(keycode[7:0]);
    assign press       = keys_now & ~keys_prev_q;
    assign window_open = (fc_q >= WIN_OPEN);
    assign judge_now   = (state_q == S_PLAY) && (press != 3'b000) && !judged_q
                         && (lane_req != 3'b000) && window_open;
    assign row_end     = frame_tick && (fc_q == FC_LAST);
    assign score_sum   = {1'b0, score_q} + POINTS_X;

    // Next-state logic. Within PLAY the press is judged before the row-end
    // bookkeeping so that a press landing on the final frame tick is scored
    // against the row that is ending, and a judged row never gets a second
    // (row-end) miss.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        fc_d        = fc_q;
        score_d     = score_q;
        streak_d    = streak_q;
        judged_d    = judged_q;
        keys_prev_d = keys_now;
        hit_d       = 1'b0;
        miss_d      = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_PLAY;
                    row_d    = '0;
                    fc_d     = '0;
                    score_d  = '0;
                    streak_d = '0;
                    judged_d = 1'b0;
                end
            end

            S_PLAY: begin
                if (judge_now) begin
                    judged_d = 1'b1;
                    if (press == lane_req) begin
                        hit_d    = 1'b1;
                        score_d  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                        streak_d = (streak_q == 8'hFF) ? 8'hFF : streak_q + 8'd1;
                    end else begin
                        miss_d   = 1'b1;
                        streak_d = '0;
                    end
                end

                if (frame_tick) begin
                    if (row_end) begin
                        if (!judged_q && !judge_now && (lane_req != 3'b000)) begin
                            miss_d   = 1'b1;
                            streak_d = '0;
                        end
                        judged_d = 1'b0;
                        fc_d     = '0;
                        if (row_q == ROW_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        fc_d = fc_q + FC_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        playing_d = (state_d == S_PLAY);
        done_d    = (state_d == S_DONE);
    end

    // All state and every output live in this one register bank.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            fc_q        <= '0;
            score_q     <= '0;
            streak_q    <= '0;
            judged_q    <= 1'b0;
            keys_prev_q <= '0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            playing_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            fc_q        <= fc_d;
            score_q     <= score_d;
            streak_q    <= streak_d;
            judged_q    <= judged_d;
            keys_prev_q <= keys_prev_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            playing_q   <= playing_d;
            done_q      <= done_d;
        end
    end

    assign row_counter = row_q;
    assign score       = score_q;
    assign streak      = streak_q;
    assign hit         = hit_q;
    assign miss        = miss_q;
    assign playing     = playing_q;
    assign done        = done_q;

endmodule

// File: tb/tb_note_judge_ctrl.sv
// ---------------------------------------------------------------------------
// tb_note_judge_ctrl
//
// Drives a default-sized note_judge_ctrl through directed and random songs
// and a small-frame 300-row instance through a long hit run. Each row is
// described by a short press plan; a row-level model applies the scoring
// rules to that plan and queues the hit/miss events it expects, and a
// monitor pops one event each time the DUT pulses hit or miss.
// ---------------------------------------------------------------------------
module tb_note_judge_ctrl;

    localparam int NR  = 100;
    localparam int RF  = 30;
    localparam int WIN = 8;
    localparam int PTS = 10;

    typedef struct {
        logic        isHit;
        int          score;
        int          streak;
        int          row;
    } evt_t;

    logic        Clk;
    logic        Reset_n;

    logic        tickA, startA;
    logic [15:0] keyA;
    logic [2:0]  laneA;
    logic [6:0]  rowA;
    logic [15:0] scoreA;
    logic [7:0]  streakA;
    logic        hitA, missA, playA, doneA;

    logic        tickB, startB;
    logic [15:0] keyB;
    logic [8:0]  rowB;
    logic [15:0] scoreB;
    logic [7:0]  streakB;
    logic        hitB, missB, playB, doneB;

    logic [2:0]  notesA [0:NR-1];

    evt_t        expQ [$];
    evt_t        popped;
    int          checkCount = 0;
    int          errCount   = 0;
    int          mScore, mStreak;
    bit          mJudged;
    int          hitsB = 0, missesB = 0;

    // Per-row press plan: up to two presses at given frame counts, plus an
    // optional press landing on the row-ending frame tick.
    int          planN;
    int          planF [2];
    logic [15:0] planK [2];
    logic [15:0] planEndK;
    logic        startNoise;

    note_judge_ctrl dutA (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_tick  (tickA),
        .start       (startA),
        .keycode     (keyA),
        .lane_req    (laneA),
        .row_counter (rowA),
        .score       (scoreA),
        .streak      (streakA),
        .hit         (hitA),
        .miss        (missA),
        .playing     (playA),
        .done        (doneA)
    );

    note_judge_ctrl #(
        .NUM_ROWS   (300),
        .ROW_FRAMES (4),
        .WINDOW     (2),
        .POINTS     (10),
        .ROW_W      (9)
    ) dutB (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_tick  (tickB),
        .start       (startB),
        .keycode     (keyB),
        .lane_req    (3'b010),
        .row_counter (rowB),
        .score       (scoreB),
        .streak      (streakB),
        .hit         (hitB),
        .miss        (missB),
        .playing     (playB),
        .done        (doneB)
    );

    assign laneA = notesA[rowA];

    // 100 MHz clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Safety net so the run always ends
    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [2:0] byteLane(input logic [7:0] b);
        if (b == 8'h0D) return 3'b100;
        if (b == 8'h0E) return 3'b010;
        if (b == 8'h0F) return 3'b001;
        return 3'b000;
    endfunction

    function automatic logic [2:0] keyVec(input logic [15:0] k);
        return byteLane(k[15:8]) | byteLane(k[7:0]);
    endfunction

    function automatic logic [7:0] laneByte(input logic [2:0] v);
        if (v == 3'b100) return 8'h0D;
        if (v == 3'b010) return 8'h0E;
        return 8'h0F;
    endfunction

    function automatic logic [2:0] randLane();
        logic [2:0] one;
        one = 3'b001;
        return one << $urandom_range(0, 2);
    endfunction

    function automatic logic [2:0] otherLane(input logic [2:0] v);
        logic [2:0] o;
        o = randLane();
        while (o == v) o = randLane();
        return o;
    endfunction

    // Single lane scancode, placed in a random byte with a non-key filler.
    function automatic logic [15:0] encode1(input logic [2:0] v);
        logic [7:0] fill;
        fill = 8'($urandom_range(0, 12));
        if ($urandom_range(0, 1) == 1) return {laneByte(v), fill};
        return {fill, laneByte(v)};
    endfunction

    function automatic int nextRow(input int row);
        return (row == NR - 1) ? row : row + 1;
    endfunction

    task automatic pushEvt(input logic isHit, input int row);
        evt_t e;
        e.isHit  = isHit;
        e.score  = mScore;
        e.streak = mStreak;
        e.row    = row;
        expQ.push_back(e);
    endtask

    // Scoring rules applied to one press of the current row.
    task automatic modelPress(input int row, input int fc, input logic [15:0] k, input bit atEnd);
        logic [2:0] v;
        int         evRow;
        v     = keyVec(k);
        evRow = atEnd ? nextRow(row) : row;
        if (v != 3'b000 && !mJudged && notesA[row] != 3'b000 && fc >= RF - WIN) begin
            mJudged = 1'b1;
            if (v == notesA[row]) begin
                mScore  = (mScore + PTS > 65535) ? 65535 : mScore + PTS;
                mStreak = (mStreak + 1 > 255) ? 255 : mStreak + 1;
                pushEvt(1'b1, evRow);
            end else begin
                mStreak = 0;
                pushEvt(1'b0, evRow);
            end
        end
    endtask

    task automatic setPlan(input int f0, input logic [15:0] k0, input int f1,
                           input logic [15:0] k1, input logic [15:0] endK);
        planN    = (f0 < 0) ? 0 : ((f1 < 0) ? 1 : 2);
        planF[0] = f0;
        planK[0] = k0;
        planF[1] = f1;
        planK[1] = k1;
        planEndK = endK;
    endtask

    // Random press plan for one row, built from the row's note.
    task automatic randomPlan(input int row, input int action);
        logic [2:0] good, bad;
        int         f;
        good = (notesA[row] != 3'b000) ? notesA[row] : randLane();
        bad  = otherLane(good);
        f    = $urandom_range(RF - WIN, RF - 1);
        case (action)
            1: setPlan(f, encode1(good), -1, 16'h0, 16'h0);
            2: setPlan(f, encode1(bad), -1, 16'h0, 16'h0);
            3: setPlan($urandom_range(0, RF - WIN - 1), encode1(good), -1, 16'h0, 16'h0);
            4: setPlan(f, {laneByte(good), laneByte(bad)}, -1, 16'h0, 16'h0);
            5: begin
                f = $urandom_range(RF - WIN, RF - 2);
                setPlan(f, encode1(bad), $urandom_range(f + 1, RF - 1), encode1(good), 16'h0);
            end
            6: setPlan(-1, 16'h0, -1, 16'h0, encode1(good));
            7: setPlan($urandom_range(0, RF - WIN - 1), encode1(good), f, encode1(good), 16'h0);
            8: setPlan(-1, 16'h0, -1, 16'h0, encode1(bad));
            default: setPlan(-1, 16'h0, -1, 16'h0, 16'h0);
        endcase
    endtask

    // Play one row of dutA: three cycles per frame (press, release, tick).
    task automatic applyStimulus(input int row);
        mJudged = 1'b0;
        for (int j = 0; j < RF; j++) begin
            @(negedge Clk);
            tickA = 1'b0;
            keyA  = 16'h0;
            for (int p = 0; p < planN; p++) begin
                if (planF[p] == j) begin
                    keyA = planK[p];
                    modelPress(row, j, planK[p], 1'b0);
                end
            end
            @(negedge Clk);
            keyA   = 16'h0;
            startA = startNoise;
            @(negedge Clk);
            startA = 1'b0;
            tickA  = 1'b1;
            if (j == RF - 1 && planEndK != 16'h0) begin
                keyA = planEndK;
                modelPress(row, j, planEndK, 1'b1);
            end
        end
        if (!mJudged && notesA[row] != 3'b000) begin
            mStreak = 0;
            pushEvt(1'b0, nextRow(row));
        end
    endtask

    task automatic idleCycle();
        @(negedge Clk);
        tickA = 1'b0;
        keyA  = 16'h0;
    endtask

    task automatic startSong();
        @(negedge Clk);
        tickA  = 1'b0;
        keyA   = 16'h0;
        startA = 1'b1;
        @(negedge Clk);
        startA  = 1'b0;
        mScore  = 0;
        mStreak = 0;
        checkOutput("start_playing", playA, 1);
        checkOutput("start_done", doneA, 0);
        checkOutput("start_row", rowA, 0);
        checkOutput("start_score", scoreA, 0);
        checkOutput("start_streak", streakA, 0);
    endtask

    function automatic logic [2:0] randNote(input bit allowRest);
        if (allowRest && $urandom_range(0, 3) == 0) return 3'b000;
        return randLane();
    endfunction

    // Scoreboard monitor for dutA
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (hitA && missA) begin
                checkOutput("hit_and_miss", 1, 0);
            end else if (hitA || missA) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_pulse", hitA ? 1 : 2, 0);
                end else begin
                    popped = expQ.pop_front();
                    checkOutput("pulse_kind_hit", hitA, popped.isHit);
                    checkOutput("pulse_score", scoreA, popped.score);
                    checkOutput("pulse_streak", streakA, popped.streak);
                    checkOutput("pulse_row", rowA, popped.row);
                end
            end
        end
    end

    // Pulse counters for dutB
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (hitB) hitsB++;
            if (missB) missesB++;
        end
    end

    initial begin
        Reset_n    = 1'b1;
        tickA      = 1'b0;
        startA     = 1'b0;
        keyA       = 16'h0;
        tickB      = 1'b0;
        startB     = 1'b0;
        keyB       = 16'h0;
        startNoise = 1'b0;
        mScore     = 0;
        mStreak    = 0;
        mJudged    = 1'b0;
        for (int i = 0; i < NR; i++) notesA[i] = 3'b000;
        #1 Reset_n = 1'b0;
        #22;
        checkOutput("reset_row", rowA, 0);
        checkOutput("reset_score", scoreA, 0);
        checkOutput("reset_streak", streakA, 0);
        checkOutput("reset_hit", hitA, 0);
        checkOutput("reset_miss", missA, 0);
        checkOutput("reset_playing", playA, 0);
        checkOutput("reset_done", doneA, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (3) idleCycle();
        checkOutput("idle_no_start", playA, 0);

        // ---- Song 1: directed opening rows, random rows, reset at row 40
        for (int i = 0; i < NR; i++) notesA[i] = randNote(1'b1);
        notesA[0] = 3'b010;  notesA[1] = 3'b010;  notesA[2] = 3'b010;
        notesA[3] = 3'b001;  notesA[4] = 3'b000;  notesA[5] = 3'b100;
        notesA[6] = 3'b100;  notesA[7] = 3'b010;  notesA[8] = 3'b001;
        startSong();
        for (int r = 0; r < 40; r++) begin
            case (r)
                0: setPlan(25, 16'h000E, -1, 16'h0, 16'h0);
                1: setPlan(25, 16'h0D00, 27, 16'h000E, 16'h0);
                2: setPlan(10, 16'h000E, -1, 16'h0, 16'h0);
                3: setPlan(24, 16'h0E0F, -1, 16'h0, 16'h0);
                4: setPlan(24, 16'h000D, 26, 16'h0F00, 16'h0);
                5: setPlan(22, 16'h0D00, -1, 16'h0, 16'h0);
                6: setPlan(21, 16'h000D, -1, 16'h0, 16'h0);
                7: setPlan(-1, 16'h0, -1, 16'h0, 16'h000E);
                8: setPlan(-1, 16'h0, -1, 16'h0, 16'h0D00);
                default: randomPlan(r, $urandom_range(0, 8));
            endcase
            applyStimulus(r);
        end
        idleCycle();
        idleCycle();
        checkOutput("row40_reached", rowA, 40);
        checkOutput("row40_score", scoreA, mScore);
        checkOutput("row40_queue_drained", expQ.size(), 0);
        #2 Reset_n = 1'b0;
        #1;
        checkOutput("midsong_reset_row", rowA, 0);
        checkOutput("midsong_reset_score", scoreA, 0);
        checkOutput("midsong_reset_streak", streakA, 0);
        checkOutput("midsong_reset_playing", playA, 0);
        checkOutput("midsong_reset_done", doneA, 0);
        expQ.delete();
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            tickA = (i % 3 == 2);
            keyA  = (i % 2 == 0) ? 16'h000E : 16'h0;
        end
        idleCycle();
        checkOutput("after_reset_idle_playing", playA, 0);
        checkOutput("after_reset_idle_row", rowA, 0);

        // ---- Song 2: every row hit
        for (int i = 0; i < NR; i++) notesA[i] = randNote(1'b0);
        startSong();
        for (int r = 0; r < NR; r++) begin
            case ($urandom_range(0, 2))
                0: randomPlan(r, 1);
                1: randomPlan(r, 6);
                default: randomPlan(r, 7);
            endcase
            applyStimulus(r);
        end
        idleCycle();
        idleCycle();
        checkOutput("allhit_done", doneA, 1);
        checkOutput("allhit_playing", playA, 0);
        checkOutput("allhit_row", rowA, NR - 1);
        checkOutput("allhit_score", scoreA, 1000);
        checkOutput("allhit_streak", streakA, 100);
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            tickA = (i % 3 == 2);
            keyA  = (i % 2 == 0) ? 16'h000E : 16'h0;
        end
        idleCycle();
        checkOutput("done_hold_score", scoreA, 1000);
        checkOutput("done_hold_streak", streakA, 100);
        checkOutput("done_hold_row", rowA, NR - 1);
        checkOutput("done_hold_done", doneA, 1);

        // ---- Song 3: restart from DONE, random notes and actions, stray start
        for (int i = 0; i < NR; i++) notesA[i] = randNote(1'b1);
        startSong();
        for (int r = 0; r < NR; r++) begin
            randomPlan(r, $urandom_range(0, 8));
            startNoise = ($urandom_range(0, 7) == 0);
            applyStimulus(r);
        end
        startNoise = 1'b0;
        idleCycle();
        idleCycle();
        checkOutput("rand_done", doneA, 1);
        checkOutput("rand_score", scoreA, mScore);
        checkOutput("rand_streak", streakA, mStreak);
        checkOutput("rand_queue_drained", expQ.size(), 0);

        // ---- dutB: 260 consecutive hits, streak saturates at 255
        @(negedge Clk);
        startB = 1'b1;
        @(negedge Clk);
        startB = 1'b0;
        checkOutput("b_start_playing", playB, 1);
        for (int r = 0; r < 260; r++) begin
            for (int j = 0; j < 4; j++) begin
                @(negedge Clk);
                tickB = 1'b0;
                keyB  = (j == 2) ? 16'h000E : 16'h0;
                @(negedge Clk);
                keyB = 16'h0;
                @(negedge Clk);
                tickB = 1'b1;
            end
            if (r == 253) checkOutput("b_streak_254", streakB, 254);
            if (r == 254) checkOutput("b_streak_255", streakB, 255);
        end
        @(negedge Clk);
        tickB = 1'b0;
        @(negedge Clk);
        checkOutput("b_streak_saturated", streakB, 255);
        checkOutput("b_score", scoreB, 2600);
        checkOutput("b_hits", hitsB, 260);
        checkOutput("b_misses", missesB, 0);
        checkOutput("b_row", rowB, 260);
        checkOutput("b_done", doneB, 0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
